// File: rtl/rs_syndrome_param_if.sv
// rs_syndrome_param_if: framed symbol input and valid/ready syndrome output bundle
interface rs_syndrome_param_if #(
    parameter int NSYM = 8
);
    logic              din_val;
    logic              din_sop;
    logic              din_eop;
    logic [7:0]        din;
    logic              din_rdy;
    logic              syn_val;
    logic              syn_rdy;
    logic [NSYM*8-1:0] syndrome;
    logic              syn_zero;
    logic              len_err;

    modport master (
        output din_val, din_sop, din_eop, din, syn_rdy,
        input  din_rdy, syn_val, syndrome, syn_zero, len_err
    );

    modport slave (
        input  din_val, din_sop, din_eop, din, syn_rdy,
        output din_rdy, syn_val, syndrome, syn_zero, len_err
    );
endinterface

// File: rtl/rs_syndrome_param.sv
// rs_syndrome_param: GF(2^8) Reed-Solomon syndrome accumulator (Horner) with frame length check
module rs_syndrome_param #(
    parameter int N    = 16,
    parameter int NSYM = 8,
    parameter int FCR  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rs_syndrome_param_if.slave     bus
);
    localparam int CW = $clog2(N + 2);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_pow(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < e % 255; i++) r = gf_mul(r, 8'h02);
        return r;
    endfunction

    function automatic logic [NSYM*8-1:0] calc_roots();
        logic [NSYM*8-1:0] r;
        r = '0;
        for (int j = 0; j < NSYM; j++) r[8*j +: 8] = gf_pow(FCR + j);
        return r;
    endfunction

    // alpha^(FCR+j) for each syndrome, fixed at elaboration so every multiply is a constant XOR net
    localparam logic [NSYM*8-1:0] ROOTS = calc_roots();

    logic [NSYM-1:0][7:0] acc;
    logic [NSYM-1:0][7:0] acc_next;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;
    logic                 in_frame;
    logic                 upd;
    logic                 fire_eop;

    // input stalls only while an untaken result is held
    assign bus.din_rdy = !bus.syn_val || bus.syn_rdy;
    // beats outside a frame without sop are dropped entirely, including a stray eop
    assign upd      = bus.din_val && bus.din_rdy && (bus.din_sop || in_frame);
    assign fire_eop = upd && bus.din_eop;

    // next accumulator and saturating symbol count for the beat on the bus
    always_comb begin
        acc_next = '0;
        for (int j = 0; j < NSYM; j++)
            acc_next[j] = bus.din_sop ? bus.din : gf_mul(acc[j], ROOTS[8*j +: 8]) ^ bus.din;
        cnt_next = bus.din_sop ? CW'(1) : (cnt == CW'(N + 1) ? cnt : cnt + CW'(1));
    end

    // accumulator state and output register; eop loads the result even as the old one is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            cnt          <= '0;
            in_frame     <= 1'b0;
            bus.syn_val  <= 1'b0;
            bus.syndrome <= '0;
            bus.syn_zero <= 1'b0;
            bus.len_err  <= 1'b0;
        end else begin
            if (upd) begin
                acc      <= acc_next;
                cnt      <= cnt_next;
                in_frame <= !bus.din_eop;
            end
            if (fire_eop) begin
                bus.syn_val  <= 1'b1;
                bus.syndrome <= acc_next;
                bus.syn_zero <= acc_next == '0;
                bus.len_err  <= cnt_next != CW'(N);
            end else if (bus.syn_rdy) begin
                bus.syn_val  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rs_syndrome_param.sv
// tb_rs_syndrome_param: directed checks of syndromes, length errors, backpressure and reset
module tb_rs_syndrome_param;
    localparam int N = 16, NSYM = 8, FCR = 1;
    localparam int W = NSYM * 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rs_syndrome_param_if #(.NSYM(NSYM)) bus();
    rs_syndrome_param #(.N(N), .NSYM(NSYM), .FCR(FCR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_err = 0;
    int n_chk = 0;
    logic [7:0] gexp [0:254];
    logic [7:0] glog [0:255];
    logic [7:0] fr [0:31];
    logic [W-1:0] a_syn;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(int'(glog[a]) + int'(glog[b])) % 255];
    endfunction

    // direct polynomial evaluation: S_j = sum fr[i] * alpha^((FCR+j)*(len-1-i))
    function automatic logic [W-1:0] model(input int len);
        logic [W-1:0] r;
        logic [7:0] s;
        r = '0;
        for (int j = 0; j < NSYM; j++) begin
            s = 8'h00;
            for (int i = 0; i < len; i++) s = s ^ gmul(fr[i], gexp[((FCR + j) * (len - 1 - i)) % 255]);
            r[8*j +: 8] = s;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
        n_chk++;
        assert (got === expv) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // starts and ends at a falling edge; holds the beat until accepted
    task automatic beat(input logic s, input logic e, input logic [7:0] d);
        int k;
        bus.din_val = 1'b1;
        bus.din_sop = s;
        bus.din_eop = e;
        bus.din     = d;
        k = 0;
        while (!bus.din_rdy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k == 100) chk("rdy_timeout", W'(bus.din_rdy), W'(1));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int len, input bit sop_first = 1'b1, input bit eop_last = 1'b1);
        for (int i = 0; i < len; i++) beat(i == 0 && sop_first, i == len - 1 && eop_last, fr[i]);
        bus.din_val = 1'b0;
        bus.din_sop = 1'b0;
        bus.din_eop = 1'b0;
    endtask

    task automatic check_res(input string tag, input int len);
        logic [W-1:0] e;
        e = model(len);
        chk({tag, "_val"}, W'(bus.syn_val), W'(1));
        chk({tag, "_syn"}, bus.syndrome, e);
        chk({tag, "_zero"}, W'(bus.syn_zero), W'(e == '0));
        chk({tag, "_len"}, W'(bus.len_err), W'(len != N));
    endtask

    initial begin
        logic [7:0] g;
        g = 8'h01;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = g;
            glog[g] = 8'(i);
            g = g[7] ? ({g[6:0], 1'b0} ^ 8'h1d) : {g[6:0], 1'b0};
        end
        bus.din_val = 1'b0;
        bus.din_sop = 1'b0;
        bus.din_eop = 1'b0;
        bus.din     = 8'h00;
        bus.syn_rdy = 1'b1;

        #1 rst_n = 1'b0;
        #11;
        chk("rst_val", W'(bus.syn_val), W'(0));
        chk("rst_rdy", W'(bus.din_rdy), W'(1));
        chk("rst_syn", bus.syndrome, '0);
        chk("rst_zero", W'(bus.syn_zero), W'(0));
        chk("rst_len", W'(bus.len_err), W'(0));
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 32; i++) fr[i] = 8'h00;
        send(16);
        check_res("zeros", 16);
        chk("zeros_flag", W'(bus.syn_zero), W'(1));
        @(negedge clk);
        chk("val_drop", W'(bus.syn_val), W'(0));

        fr[15] = 8'h01;
        send(16);
        check_res("last1", 16);
        chk("last1_all", bus.syndrome, {NSYM{8'h01}});

        fr[15] = 8'h00;
        fr[0]  = 8'h01;
        send(16);
        check_res("first1", 16);
        chk("first1_s0", W'(bus.syndrome[7:0]), W'(8'h26));

        for (int i = 0; i < 32; i++) fr[i] = 8'(i * 37 + 5);
        send(16);
        check_res("pat", 16);

        send(10);
        check_res("short", 10);
        chk("short_err", W'(bus.len_err), W'(1));

        for (int i = 0; i < 32; i++) fr[i] = 8'(i + 1);
        send(20);
        check_res("long", 20);

        for (int i = 0; i < 32; i++) fr[i] = 8'(8'hc3 ^ i);
        send(5, 1'b1, 1'b0);
        chk("open_noval", W'(bus.syn_val), W'(0));
        for (int i = 0; i < 32; i++) fr[i] = 8'(i * 11 + 2);
        send(16);
        check_res("restart", 16);

        fr[0] = 8'h5a;
        send(1);
        check_res("single", 1);
        chk("single_all", bus.syndrome, {NSYM{8'h5a}});

        for (int i = 0; i < 32; i++) fr[i] = 8'(i * 7 + 9);
        send(16);
        check_res("b2b_a", 16);
        for (int i = 0; i < 32; i++) fr[i] = 8'(255 - i * 3);
        send(16);
        check_res("b2b_b", 16);

        @(negedge clk);
        bus.syn_rdy = 1'b0;
        for (int i = 0; i < 32; i++) fr[i] = 8'(i * 29 + 1);
        a_syn = model(16);
        send(16);
        check_res("bp_a", 16);
        chk("bp_rdy_low", W'(bus.din_rdy), W'(0));
        for (int i = 0; i < 32; i++) fr[i] = 8'(i * 13 + 100);
        bus.din_val = 1'b1;
        bus.din_sop = 1'b1;
        bus.din_eop = 1'b0;
        bus.din     = fr[0];
        repeat (3) @(negedge clk);
        chk("bp_hold_rdy", W'(bus.din_rdy), W'(0));
        chk("bp_hold_val", W'(bus.syn_val), W'(1));
        chk("bp_hold_syn", bus.syndrome, a_syn);
        bus.syn_rdy = 1'b1;
        #1;
        chk("bp_rdy_up", W'(bus.din_rdy), W'(1));
        beat(1'b1, 1'b0, fr[0]);
        chk("bp_a_taken", W'(bus.syn_val), W'(0));
        for (int i = 1; i < 16; i++) beat(1'b0, i == 15, fr[i]);
        bus.din_val = 1'b0;
        bus.din_eop = 1'b0;
        check_res("bp_b", 16);

        @(negedge clk);
        bus.syn_rdy = 1'b0;
        send(16);
        chk("rstmid_val_pre", W'(bus.syn_val), W'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_val", W'(bus.syn_val), W'(0));
        chk("rstmid_syn", bus.syndrome, '0);
        chk("rstmid_len", W'(bus.len_err), W'(0));
        chk("rstmid_rdy", W'(bus.din_rdy), W'(1));
        @(negedge clk) rst_n = 1'b1;
        bus.syn_rdy = 1'b1;
        send(5, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        beat(1'b0, 1'b1, 8'h33);
        bus.din_val = 1'b0;
        bus.din_eop = 1'b0;
        chk("stray_eop", W'(bus.syn_val), W'(0));
        for (int i = 0; i < 32; i++) fr[i] = 8'(i * 5 + 77);
        send(16);
        check_res("post_rst", 16);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
